// File: rtl/rgb_pixel_ctrl.sv
// rtl/rgb_pixel_ctrl.sv - RGB pixel colour generator with debounced per-channel level buttons
// Channel index 0/1/2 = red/green/blue throughout.
module rgb_pixel_ctrl #(
  parameter int COLOR_W      = 4,
  parameter int STEP         = 15,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               boton_r,
  input  logic               boton_g,
  input  logic               boton_b,
  input  logic               bit_fuente,
  input  logic               h_on,
  input  logic               v_on,
  input  logic [1:0]         modo,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic [COLOR_W-1:0] lvl_r,
  output logic [COLOR_W-1:0] lvl_g,
  output logic [COLOR_W-1:0] lvl_b
);

  localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [COLOR_W:0] MAX_W  = (COLOR_W+1)'((1 << COLOR_W) - 1);
  localparam logic [COLOR_W:0] STEP_W = (COLOR_W+1)'(STEP);

  logic [2:0]         btn;
  logic [2:0]         s1_q, s1_d, s2_q, s2_d;
  logic [2:0]         deb_q, deb_d, debp_q, debp_d;
  logic [2:0]         press;
  logic [CNT_W-1:0]   cnt_q [3];
  logic [CNT_W-1:0]   cnt_d [3];
  logic [COLOR_W-1:0] lvl_q [3];
  logic [COLOR_W-1:0] lvl_d [3];
  logic [COLOR_W-1:0] pix_q [3];
  logic [COLOR_W-1:0] pix_d [3];
  logic [COLOR_W:0]   sum   [3];
  logic               vis;

  assign btn = {boton_b, boton_g, boton_r};
  assign vis = h_on & v_on;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      s1_d[i]   = btn[i];
      s2_d[i]   = s1_q[i];
      deb_d[i]  = deb_q[i];
      debp_d[i] = deb_q[i];
      cnt_d[i]  = '0;
      lvl_d[i]  = lvl_q[i];
      pix_d[i]  = '0;
      sum[i]    = {1'b0, lvl_q[i]} + STEP_W;
      // Press is a rise of the debounced state; debp_q is cleared by reset so no false event.
      press[i]  = deb_q[i] & ~debp_q[i];

      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = s2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end

      if (press[i]) lvl_d[i] = (sum[i] > MAX_W) ? '0 : sum[i][COLOR_W-1:0];

      if (vis) begin
        case (modo)
          2'b00:   pix_d[i] = bit_fuente ? lvl_q[i] : '0;
          2'b01:   pix_d[i] = bit_fuente ? '0 : lvl_q[i];
          2'b10:   pix_d[i] = lvl_q[i];
          default: pix_d[i] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      deb_q  <= '0;
      debp_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
        lvl_q[i] <= '0;
        pix_q[i] <= '0;
      end
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      deb_q  <= deb_d;
      debp_q <= debp_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
        lvl_q[i] <= lvl_d[i];
        pix_q[i] <= pix_d[i];
      end
    end
  end

  assign r     = pix_q[0];
  assign g     = pix_q[1];
  assign b     = pix_q[2];
  assign lvl_r = lvl_q[0];
  assign lvl_g = lvl_q[1];
  assign lvl_b = lvl_q[2];

endmodule

// File: tb/tb_rgb_pixel_ctrl.sv
// tb/tb_rgb_pixel_ctrl.sv - directed self-checking bench for rgb_pixel_ctrl
module tb_rgb_pixel_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       boton_r, boton_g, boton_b, bit_fuente, h_on, v_on;
  logic [1:0] modo;
  logic [3:0] r, g, b, lvl_r, lvl_g, lvl_b;
  logic       boton_r6, tie0;
  logic [3:0] r6, g6, b6, lvl_r6, lvl_g6, lvl_b6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rgb_pixel_ctrl #(.COLOR_W(4), .STEP(15), .DEBOUNCE_CYC(4)) dut (
    .clk(clk), .reset(reset), .boton_r(boton_r), .boton_g(boton_g), .boton_b(boton_b),
    .bit_fuente(bit_fuente), .h_on(h_on), .v_on(v_on), .modo(modo),
    .r(r), .g(g), .b(b), .lvl_r(lvl_r), .lvl_g(lvl_g), .lvl_b(lvl_b)
  );

  rgb_pixel_ctrl #(.COLOR_W(4), .STEP(6), .DEBOUNCE_CYC(4)) dut6 (
    .clk(clk), .reset(reset), .boton_r(boton_r6), .boton_g(tie0), .boton_b(tie0),
    .bit_fuente(bit_fuente), .h_on(h_on), .v_on(v_on), .modo(modo),
    .r(r6), .g(g6), .b(b6), .lvl_r(lvl_r6), .lvl_g(lvl_g6), .lvl_b(lvl_b6)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, return at the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; boton_r = 0; boton_g = 0; boton_b = 0; boton_r6 = 0; tie0 = 0;
    bit_fuente = 0; h_on = 0; v_on = 0; modo = 2'b00;
    #2;
    check_eq("rst_r", r, 0);
    check_eq("rst_lvl_r", lvl_r, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: visible glyph pixel with zero levels
    h_on = 1; v_on = 1; modo = 2'b00; bit_fuente = 1;
    tick(1);
    check_eq("t1_r", r, 0);
    check_eq("t1_g", g, 0);
    check_eq("t1_b", b, 0);

    // 2: clean red press, latency 7 to lvl_r, 8 to r
    boton_r = 1;
    tick(6);
    check_eq("t2_lvl_r_at6", lvl_r, 0);
    tick(1);
    check_eq("t2_lvl_r_at7", lvl_r, 15);
    check_eq("t2_r_at7", r, 0);
    tick(1);
    check_eq("t2_r_at8", r, 15);
    check_eq("t2_g", g, 0);
    check_eq("t2_b", b, 0);
    tick(20);
    check_eq("t2_held_one_event", lvl_r, 15);

    // 3: bouncing green press yields a single event
    boton_g = 1; tick(1); @(posedge clk); @(negedge clk);
    boton_g = 0; tick(1); @(posedge clk); @(negedge clk);
    boton_g = 1;
    tick(3);
    check_eq("t3_no_early_event", lvl_g, 0);
    tick(20);
    check_eq("t3_lvl_g", lvl_g, 15);

    // 4: display modes and blanking
    modo = 2'b01; bit_fuente = 1;
    tick(1);
    check_eq("t4_inv_glyph_r", r, 0);
    check_eq("t4_inv_glyph_g", g, 0);
    bit_fuente = 0;
    tick(1);
    check_eq("t4_inv_bg_r", r, 15);
    check_eq("t4_inv_bg_g", g, 15);
    check_eq("t4_inv_bg_b", b, 0);
    v_on = 0;
    tick(1);
    check_eq("t4_blank_r", r, 0);
    check_eq("t4_blank_g", g, 0);
    v_on = 1; modo = 2'b10; bit_fuente = 0;
    tick(1);
    check_eq("t4_solid_r", r, 15);
    modo = 2'b11;
    tick(1);
    check_eq("t4_black_r", r, 0);
    modo = 2'b00; bit_fuente = 1;

    // 5: STEP=6 wrap sequence
    begin
      logic [3:0] exp_lvl [4];
      exp_lvl[0] = 6; exp_lvl[1] = 12; exp_lvl[2] = 0; exp_lvl[3] = 6;
      for (int i = 0; i < 4; i++) begin
        boton_r6 = 1;
        tick(10);
        check_eq($sformatf("t5_press%0d", i), lvl_r6, exp_lvl[i]);
        boton_r6 = 0;
        tick(10);
      end
    end

    // 6: reset in the middle of a blue debounce
    boton_r = 0; boton_g = 0;
    tick(12);
    check_eq("t6_release_no_event", lvl_r, 15);
    boton_b = 1;
    tick(4);
    reset = 1;
    #1;
    check_eq("t6_async_clear_r", lvl_r, 0);
    check_eq("t6_async_clear_g", lvl_g, 0);
    @(negedge clk);
    reset = 0;
    tick(6);
    check_eq("t6_lvl_b_at6", lvl_b, 0);
    tick(1);
    check_eq("t6_lvl_b_at7", lvl_b, 15);
    boton_b = 0;
    tick(12);
    boton_r = 1; boton_b = 1;
    tick(6);
    check_eq("t6_sim_r_at6", lvl_r, 0);
    check_eq("t6_sim_b_at6", lvl_b, 15);
    tick(1);
    check_eq("t6_sim_r_at7", lvl_r, 15);
    check_eq("t6_sim_b_at7", lvl_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
